// File: rtl/bp_be_fe_queue_buffer.sv
`default_nettype none
// ============================================================================
// Module   : bp_be_fe_queue_buffer
// Brief    : Backend-side fe_queue buffer with speculative dequeue, commit,
//            rollback replay and redirect flush.
// Revision : 1.0 - initial release
// ============================================================================
module bp_be_fe_queue_buffer #(
   parameter int els_p   = 8,
   parameter int width_p = 128
) (
   input  logic                       clk_i,
   input  logic                       reset_i,
   input  logic [width_p-1:0]         fe_queue_i,
   input  logic                       fe_queue_v_i,
   output logic                       fe_queue_ready_and_o,
   output logic [width_p-1:0]         fe_queue_o,
   output logic                       fe_queue_v_o,
   input  logic                       fe_queue_yumi_i,
   input  logic                       commit_i,
   input  logic                       rollback_i,
   input  logic                       clr_i,
   output logic [$clog2(els_p):0]     count_o
);

   // Pointers carry one extra wrap bit so that full and empty are distinct.
   localparam int PTR_W = $clog2(els_p) + 1;
   localparam int IDX_W = PTR_W - 1;

   logic [width_p-1:0] mem [els_p];

   logic [PTR_W-1:0] wptr;
   logic [PTR_W-1:0] rptr;
   logic [PTR_W-1:0] cptr;

   logic [PTR_W-1:0] cptr_next;
   logic [PTR_W-1:0] rptr_next;
   logic [PTR_W-1:0] count;
   logic [PTR_W-1:0] rd_dist;
   logic             full;
   logic             enq;
   logic             deq;
   logic             commit_ok;

   // Occupancy and handshake qualifiers; ready depends on state only.
   always_comb begin
      count     = wptr - cptr;
      rd_dist   = rptr - cptr;
      full      = (count == PTR_W'(els_p));
      enq       = fe_queue_v_i & ~full;
      deq       = fe_queue_yumi_i & (rptr != wptr);
      commit_ok = commit_i & (cptr != rptr);
      cptr_next = cptr + PTR_W'(commit_ok);
      // Rollback rewinds to the oldest uncommitted entry, after this cycle's commit.
      if (rollback_i) begin
         rptr_next = cptr_next;
      end else if (deq) begin
         rptr_next = rptr + PTR_W'(1);
      end else begin
         rptr_next = rptr;
      end
   end

   assign fe_queue_ready_and_o = ~full;
   assign fe_queue_v_o         = (rptr != wptr);
   assign fe_queue_o           = mem[rptr[IDX_W-1:0]];
   assign count_o              = count;

   // Pointer state; clear overrides every other same-cycle action.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         wptr <= '0;
         rptr <= '0;
         cptr <= '0;
      end else if (clr_i) begin
         wptr <= '0;
         rptr <= '0;
         cptr <= '0;
      end else begin
         wptr <= wptr + PTR_W'(enq);
         rptr <= rptr_next;
         cptr <= cptr_next;
      end
   end

   // Packet storage, intentionally not reset; a flushed write is unreachable.
   always_ff @(posedge clk_i) begin
      if (enq) begin
         mem[wptr[IDX_W-1:0]] <= fe_queue_i;
      end
   end

`ifndef SYNTHESIS
   // Commit must retire an entry that has already been dequeued.
   a_commit_legal : assert property (@(posedge clk_i) disable iff (reset_i)
      commit_i |-> (cptr != rptr));

   // Consumer may only take a packet that is actually presented.
   a_yumi_legal : assert property (@(posedge clk_i) disable iff (reset_i)
      fe_queue_yumi_i |-> fe_queue_v_o);

   // Pointer ordering cptr <= rptr <= wptr within one buffer depth.
   a_ptr_order : assert property (@(posedge clk_i) disable iff (reset_i)
      (rd_dist <= count) && (count <= PTR_W'(els_p)));
`endif

endmodule
`default_nettype wire

// File: tb/tb_bp_be_fe_queue_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_bp_be_fe_queue_buffer
// Brief    : Self-checking bench for bp_be_fe_queue_buffer against a
//            queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bp_be_fe_queue_buffer;

   localparam int ELS = 8;
   localparam int W   = 128;

   logic           clk = 1'b0;
   logic           reset_i = 1'b0;
   logic [W-1:0]   fe_queue_i = '0;
   logic           fe_queue_v_i = 1'b0;
   logic           fe_queue_ready_and_o;
   logic [W-1:0]   fe_queue_o;
   logic           fe_queue_v_o;
   logic           fe_queue_yumi_i = 1'b0;
   logic           commit_i = 1'b0;
   logic           rollback_i = 1'b0;
   logic           clr_i = 1'b0;
   logic [3:0]     count_o;

   // Free-running clock.
   always #5 clk = ~clk;

   bp_be_fe_queue_buffer #(.els_p(ELS), .width_p(W)) dut (
      .clk_i                (clk),
      .reset_i              (reset_i),
      .fe_queue_i           (fe_queue_i),
      .fe_queue_v_i         (fe_queue_v_i),
      .fe_queue_ready_and_o (fe_queue_ready_and_o),
      .fe_queue_o           (fe_queue_o),
      .fe_queue_v_o         (fe_queue_v_o),
      .fe_queue_yumi_i      (fe_queue_yumi_i),
      .commit_i             (commit_i),
      .rollback_i           (rollback_i),
      .clr_i                (clr_i),
      .count_o              (count_o)
   );

   int errors = 0;
   int checks = 0;

   // Reference model: resident packets oldest first, and how many of them
   // have been speculatively read.
   logic [W-1:0] q [$];
   int           n_rd = 0;

   function automatic logic [W-1:0] rnd_pkt();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   task automatic check_value(input string tag, input logic [W-1:0] obs,
                              input logic [W-1:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic check_outputs();
      logic exp_v;
      exp_v = (n_rd < q.size());
      check_value("ready", W'(fe_queue_ready_and_o), W'(q.size() < ELS));
      check_value("v_o",   W'(fe_queue_v_o), W'(exp_v));
      check_value("count", W'(count_o), W'(q.size()));
      if (exp_v) check_value("data", fe_queue_o, q[n_rd]);
   endtask

   // One clock cycle: check outputs, drive inputs, advance the model.
   task automatic cyc(input logic v, input logic [W-1:0] d, input logic y,
                      input logic c, input logic rb, input logic cl);
      logic acc;
      check_outputs();
      fe_queue_v_i    = v;
      fe_queue_i      = d;
      fe_queue_yumi_i = y;
      commit_i        = c;
      rollback_i      = rb;
      clr_i           = cl;
      acc = v && (q.size() < ELS);
      if (cl) begin
         q.delete();
         n_rd = 0;
      end else begin
         if (c) begin
            void'(q.pop_front());
            n_rd--;
         end
         if (rb)     n_rd = 0;
         else if (y) n_rd++;
         if (acc)    q.push_back(d);
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle();
      cyc(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic enq(input logic [W-1:0] d);
      cyc(1'b1, d, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic yumi();
      cyc(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic commit();
      cyc(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
   endtask

   task automatic clear();
      cyc(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
   endtask

   // Read and commit everything left, with a bounded cycle budget.
   task automatic drain();
      int budget;
      budget = 4 * ELS + 8;
      while (q.size() > 0 && budget > 0) begin
         cyc(1'b0, '0, logic'(n_rd < q.size()), logic'(n_rd > 0), 1'b0, 1'b0);
         budget--;
      end
      check_value("drain_budget", W'(q.size()), '0);
   endtask

   // Directed scenarios followed by random traffic.
   initial begin
      logic v, y, c, rb, cl;
      #1 reset_i = 1'b1;
      repeat (2) @(negedge clk);
      check_outputs();
      reset_i = 1'b0;

      // Basic enqueue, speculative dequeue and commit.
      enq(rnd_pkt()); enq(rnd_pkt()); enq(rnd_pkt());
      yumi(); yumi(); yumi();
      idle();
      commit(); commit(); commit();
      idle();

      // Fill to full, commit-with-blocked-enqueue, then wrap.
      for (int i = 0; i < ELS; i++) enq(rnd_pkt());
      enq(rnd_pkt());
      yumi();
      cyc(1'b1, rnd_pkt(), 1'b0, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < ELS; i++)
         cyc(1'b1, rnd_pkt(), logic'(n_rd < q.size()), logic'(n_rd > 0), 1'b0, 1'b0);
      drain();
      idle();

      // Rollback replays uncommitted entries.
      clear();
      for (int i = 0; i < 5; i++) enq(rnd_pkt());
      yumi(); yumi(); yumi();
      commit();
      cyc(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
      yumi(); yumi(); yumi(); yumi();
      drain();

      // Rollback, yumi and commit together.
      clear();
      enq(rnd_pkt()); enq(rnd_pkt()); enq(rnd_pkt());
      yumi(); yumi();
      cyc(1'b0, '0, 1'b1, 1'b1, 1'b1, 1'b0);
      idle();

      // Clear with an accepted enqueue in the same cycle.
      clear();
      for (int i = 0; i < 5; i++) enq(rnd_pkt());
      cyc(1'b1, rnd_pkt(), 1'b0, 1'b0, 1'b0, 1'b1);
      idle();

      // Asynchronous reset between clock edges with entries resident.
      for (int i = 0; i < 4; i++) enq(rnd_pkt());
      yumi();
      fe_queue_v_i = 1'b0;
      fe_queue_yumi_i = 1'b0;
      #2 reset_i = 1'b1;
      #1;
      check_value("async_rst_v",     W'(fe_queue_v_o), '0);
      check_value("async_rst_ready", W'(fe_queue_ready_and_o), W'(1));
      check_value("async_rst_count", W'(count_o), '0);
      q.delete();
      n_rd = 0;
      @(negedge clk);
      reset_i = 1'b0;
      idle();

      // Random traffic with legal yumi/commit.
      for (int i = 0; i < 400; i++) begin
         v  = ($urandom_range(0, 9) < 6);
         y  = (n_rd < q.size()) && ($urandom_range(0, 1) == 1);
         c  = (n_rd > 0) && ($urandom_range(0, 2) == 0);
         rb = ($urandom_range(0, 15) == 0);
         cl = ($urandom_range(0, 49) == 0);
         cyc(v, rnd_pkt(), y, c, rb, cl);
      end
      idle();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
